// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_fifo.sv
// Circular-buffer FIFO, first-word fall-through (dout is the head); push ignored when full, pop ignored when empty.
// Simultaneous push and pop keeps occupancy; pointers wrap modulo DEPTH (power of 2).
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU (A, priority) and mult/div (B, FIFO-buffered) writebacks into one registered write port; A 1 cycle, B >=2 cycles
// (1 with WB_BYPASS_EN when idle). B stalls when FIFO full; A stalls only for the one cycle a starved B head is forced through.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [REG_ADDR_W-1:0]      a_reg,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [REG_ADDR_W-1:0]      b_reg,
  input  logic [DATA_W-1:0]          b_data,
  output logic                       RegWrite,
  output logic [REG_ADDR_W-1:0]      WriteReg,
  output logic [DATA_W-1:0]          WriteData,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int WAIT_W = $clog2(MAX_WAIT+1);

  wb_req_t a_req, b_req, head, win_req;
  logic    fifo_full, fifo_empty;
  logic    force_b, a_win, b_pop, b_byp, b_push, has_win;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

  wb_fifo #(.DEPTH(DEPTH), .W(WB_REQ_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .pop   (b_pop),
    .din   (b_req),
    .dout  (head),
    .count (pending),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    a_req.rd   = a_reg;
    a_req.data = a_data;
    b_req.rd   = b_reg;
    b_req.data = b_data;

    force_b = !fifo_empty && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    a_ready = !force_b;
    b_ready = !fifo_full;
    a_win   = a_valid && !force_b;
    b_pop   = !a_win && !fifo_empty;
`ifdef WB_BYPASS_EN
    b_byp   = !a_win && fifo_empty && b_valid;
`else
    b_byp   = 1'b0;
`endif
    b_push  = b_valid && !fifo_full && !b_byp;
    has_win = a_win || b_pop || b_byp;

    win_req = a_req;
    if (b_pop)      win_req = head;
    else if (b_byp) win_req = b_req;

    // r0 writes are consumed and still move the address/data, only the enable is held low.
    reg_write_d  = has_win && (win_req.rd != ZERO_REG);
    write_reg_d  = has_win ? win_req.rd   : write_reg_q;
    write_data_d = has_win ? win_req.data : write_data_q;

    wait_cnt_d = wait_cnt_q;
    if (b_pop || fifo_empty)
      wait_cnt_d = '0;
    else if (a_win && (wait_cnt_q != WAIT_W'(MAX_WAIT)))
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;

endmodule
